// File: rtl/addsub_pkg.sv
// Shared types and default sizing for the chunk-serial adder/subtractor.
package addsub_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CHUNK_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit
// so the caller can form signed overflow on the most significant chunk.
module adder_chunk #(
  parameter int CHUNK = addsub_pkg::CHUNK_DEF
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder_1bit u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/full_adder_1bit.sv
// One-bit full adder cell used to build the ripple chunk.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/addsub_seq.sv
// Sequential two's-complement add/subtract: one CHUNK-bit slice per cycle through
// a single shared adder, with optional signed saturation and a valid/ready handshake.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             ovfl,
  output logic             cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SAT_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             sat_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             chunk_cmsb;
  logic             ovfl_next;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] final_sum;

  adder_chunk #(.CHUNK(CHUNK)) u_adder (
    .a     (a_q[idx*CHUNK +: CHUNK]),
    .b     (b_q[idx*CHUNK +: CHUNK]),
    .ci    (carry),
    .s     (chunk_sum),
    .co    (chunk_cout),
    .c_msb (chunk_cmsb)
  );

  // Only meaningful on the last chunk, where chunk_cmsb is the carry into bit WIDTH-1.
  always_comb begin
    ovfl_next = chunk_cmsb ^ chunk_cout;
    raw_sum   = acc;
    raw_sum[idx*CHUNK +: CHUNK] = chunk_sum;
    final_sum = raw_sum;
    if (sat_q && ovfl_next) begin
      final_sum = a_q[WIDTH-1] ? SAT_NEG : SAT_POS;
    end
  end

  // Gated by rst so nothing is offered while the block is being reset.
  assign in_ready = (state == IDLE) && !rst;

  // NOTE: every register, datapath included, is cleared by the synchronous reset and
  // updated with non-blocking assignments so all state moves together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      sat_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      ovfl      <= 1'b0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            carry <= sub;
            sat_q <= sat;
            idx   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc[idx*CHUNK +: CHUNK] <= chunk_sum;
          carry <= chunk_cout;
          if (idx == LAST_IDX) begin
            sum       <= final_sum;
            ovfl      <= ovfl_next;
            cout      <= chunk_cout;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Directed self-checking bench for addsub_seq at WIDTH=16, CHUNK=4.
module tb_addsub_seq;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             ovfl;
  logic             cout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovfl      (ovfl),
    .cout      (cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, measure latency, check result, then complete the handshake.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic ts, input logic tsat, input logic [15:0] esum,
                        input logic eovfl, input logic ecout);
    int lat;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_v; sub = ts; sat = tsat; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, " busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(NCHUNK));
    check({tag, " sum"}, 32'(sum), 32'(esum));
    check({tag, " ovfl"}, 32'(ovfl), 32'(eovfl));
    check({tag, " cout"}, 32'(cout), 32'(ecout));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; sat = 1'b0;
    tick();
    tick();
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst ovfl", 32'(ovfl), 32'd0);
    check("rst cout", 32'(cout), 32'd0);
    rst = 1'b0;
    #1;
    check("post rst in_ready", 32'(in_ready), 32'd1);

    run_op("add basic",    16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0);
    run_op("add ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0);
    run_op("add ovf sat",  16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0);
    run_op("sub ovf",      16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub ovf sat",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);
    run_op("sub zero",     16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    run_op("sub borrow",   16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    run_op("add carry",    16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1);
    run_op("add neg sat",  16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
    run_op("sub no sat",   16'h1000, 16'h0FF1, 1'b1, 1'b1, 16'h000F, 1'b0, 1'b1);

    // Back-pressure: result held in DONE while new requests are ignored.
    check("hold in_ready", 32'(in_ready), 32'd1);
    a = 16'h0100; b = 16'h0023; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
    tick();
    a = 16'h4444; b = 16'h1111; sub = 1'b1;
    for (int k = 0; k < NCHUNK; k++) tick();
    check("hold arrive", 32'(out_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold sum", 32'(sum), 32'h0123);
      check("hold in_ready", 32'(in_ready), 32'd0);
      check("hold out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold release", 32'(out_valid), 32'd0);
    run_op("after hold",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Abort: reset during the second CALC cycle.
    a = 16'h2222; b = 16'h1111; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort sum", 32'(sum), 32'd0);
    check("abort ovfl", 32'(ovfl), 32'd0);
    check("abort cout", 32'(cout), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("abort idle", 32'(in_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("abort no result", 32'(out_valid), 32'd0);
    end
    run_op("after abort",  16'h2222, 16'h1111, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
